// File: rtl/rx_ipg_demux.sv
// RX splitter: forwards network blocks to the MAC and reassembles IPG-borne memory messages.
// Optional IPG_CRC_EN: verify a CRC-8 trailer in the pad byte before committing a message.
module rx_ipg_demux #(
  parameter int unsigned MEM_W  = 520,
  parameter logic [7:0]  IPG_BT = 8'h5a,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [63:0]      rx_d,
  input  logic [1:0]       rx_c,
  output logic [63:0]      net_out_d,
  output logic [1:0]       net_out_c,
  output logic             net_out_valid,
  output logic [MEM_W-1:0] mem_out,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             ipg_err,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned NBLK  = (MEM_W + 8 + 55) / 56;
  localparam int unsigned BUF_W = NBLK * 56;
  localparam int unsigned IDX_W = $clog2(NBLK + 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NBLK - 1);

  typedef enum logic [1:0] {StGap, StFrame, StIpg} state_e;

  state_e           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [BUF_W-1:0] r_buf;
  logic [63:0]      r_net_d;
  logic [1:0]       r_net_c;
  logic             r_net_valid;
  logic [MEM_W-1:0] r_mem;
  logic             r_mem_valid;
  logic             r_ipg_err;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_is_ctrl;
  logic             w_is_ipg;
  logic             w_is_start;
  logic [IDX_W-1:0] w_idx;
  logic             w_store;
  logic             w_complete;
  logic             w_crc_ok;
  logic             w_commit;
  logic             w_err_evt;
  logic             w_hs;
  logic [BUF_W-1:0] w_buf_nxt;

  assign w_is_ctrl  = (rx_c == 2'b01);
  assign w_is_ipg   = w_is_ctrl && (rx_d[7:0] == IPG_BT);
  assign w_is_start = w_is_ctrl && (rx_d[7:0] == 8'h78 || rx_d[7:0] == 8'h33);

  // Chunk 0 always comes from GAP, so the index only advances while collecting.
  assign w_idx      = (r_state == StIpg) ? r_cnt : '0;
  assign w_store    = rx_valid && w_is_ipg && (r_state != StFrame);
  assign w_complete = w_store && (w_idx == LastIdx);

  always_comb begin
    w_buf_nxt = r_buf;
    if (w_store) w_buf_nxt[int'(w_idx)*56 +: 56] = rx_d[63:8];
  end

`ifdef IPG_CRC_EN
  function automatic logic [7:0] crc8(input logic [MEM_W-1:0] data);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = int'(MEM_W) - 1; i >= 0; i--) begin
      crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ data[i]) ? 8'h07 : 8'h00);
    end
    return crc;
  endfunction

  assign w_crc_ok = (crc8(w_buf_nxt[MEM_W-1:0]) == w_buf_nxt[MEM_W+7:MEM_W]);
`else
  assign w_crc_ok = 1'b1;
`endif

  assign w_commit  = w_complete && w_crc_ok;
  assign w_hs      = r_mem_valid && mem_ready;
  assign w_err_evt = (rx_valid && (((r_state == StFrame) && w_is_ipg) ||
                                   ((r_state == StIpg) && !w_is_ipg))) ||
                     (w_complete && !w_crc_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StGap;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_net_d     <= '0;
      r_net_c     <= '0;
      r_net_valid <= 1'b0;
      r_mem       <= '0;
      r_mem_valid <= 1'b0;
      r_ipg_err   <= 1'b0;
      r_drop_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_ipg_err   <= w_err_evt;
      r_net_valid <= rx_valid && !w_is_ipg;
      r_buf       <= w_buf_nxt;
      if (w_err_evt && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      if (rx_valid && !w_is_ipg) begin
        r_net_d <= rx_d;
        r_net_c <= rx_c;
      end

      if (w_hs) r_mem_valid <= 1'b0;
      // A same-cycle handshake frees the holding register for the new message.
      if (w_commit) begin
        if (!r_mem_valid || mem_ready) begin
          r_mem       <= w_buf_nxt[MEM_W-1:0];
          r_mem_valid <= 1'b1;
        end else if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end

      if (rx_valid) begin
        unique case (r_state)
          StGap, StIpg: begin
            if (w_is_ipg) begin
              if (w_complete) begin
                r_cnt   <= '0;
                r_state <= StGap;
              end else begin
                r_cnt   <= w_idx + 1'b1;
                r_state <= StIpg;
              end
            end else begin
              r_cnt   <= '0;
              r_state <= w_is_start ? StFrame : StGap;
            end
          end
          StFrame: begin
            if (w_is_ctrl && rx_d[7:0] inside {8'h87, 8'h99, 8'haa, 8'hb4,
                                               8'hcc, 8'hd2, 8'he1, 8'hff}) begin
              r_state <= StGap;
            end
          end
          default: r_state <= StGap;
        endcase
      end
    end
  end

  assign net_out_d     = r_net_d;
  assign net_out_c     = r_net_c;
  assign net_out_valid = r_net_valid;
  assign mem_out       = r_mem;
  assign mem_valid     = r_mem_valid;
  assign ipg_err       = r_ipg_err;
  assign drop_cnt      = r_drop_cnt;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_rx_ipg_demux.sv
// Randomised bench for rx_ipg_demux against a queue-based reference model.
module tb_rx_ipg_demux;
  localparam int unsigned MEM_W = 520;
  localparam int unsigned NBLK  = (MEM_W + 8 + 55) / 56;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_valid;
  logic [63:0]      rx_d;
  logic [1:0]       rx_c;
  logic [63:0]      net_out_d;
  logic [1:0]       net_out_c;
  logic             net_out_valid;
  logic [MEM_W-1:0] mem_out;
  logic             mem_valid;
  logic             mem_ready;
  logic             ipg_err;
  logic [15:0]      drop_cnt;
  logic [15:0]      err_cnt;

  rx_ipg_demux dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_d         (rx_d),
    .rx_c         (rx_c),
    .net_out_d    (net_out_d),
    .net_out_c    (net_out_c),
    .net_out_valid(net_out_valid),
    .mem_out      (mem_out),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .ipg_err      (ipg_err),
    .drop_cnt     (drop_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "collecting" is simply a non-empty chunk queue.
  bit               m_frame;
  logic [55:0]      m_q[$];
  bit               e_net_v;
  logic [63:0]      e_net_d;
  logic [1:0]       e_net_c;
  bit               e_memv;
  logic [MEM_W-1:0] e_mem;
  bit               e_err;
  logic [15:0]      e_drop;
  logic [15:0]      e_errcnt;

  logic [7:0] term_types[8] = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};

  task automatic check_val(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_frame = 0; m_q.delete();
    e_net_v = 0; e_net_d = '0; e_net_c = '0; e_memv = 0; e_mem = '0;
    e_err = 0; e_drop = '0; e_errcnt = '0;
  endtask

  task automatic finish_msg(input bit was_memv, input logic rdy);
    logic [NBLK*56-1:0] full;
`ifdef IPG_CRC_EN
    logic [7:0] crc;
`endif
    for (int k = 0; k < NBLK; k++) full[k*56 +: 56] = m_q[k];
    m_q.delete();
`ifdef IPG_CRC_EN
    crc = 8'h00;
    for (int i = MEM_W - 1; i >= 0; i--)
      crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ full[i]) ? 8'h07 : 8'h00);
    if (crc != full[MEM_W+7:MEM_W]) begin
      e_err = 1;
      return;
    end
`endif
    if (!was_memv || rdy) begin
      e_mem = full[MEM_W-1:0];
      e_memv = 1;
    end else if (e_drop != 16'hffff) begin
      e_drop++;
    end
  endtask

  task automatic model_step(input logic v, input logic [63:0] d, input logic [1:0] c,
                            input logic rdy);
    bit was_memv, ipg, start, term;
    logic [7:0] t;
    was_memv = e_memv;
    t = d[7:0];
    e_err = 0;
    e_net_v = 0;
    if (e_memv && rdy) e_memv = 0;
    if (v) begin
      ipg   = (c == 2'b01) && (t == 8'h5a);
      start = (c == 2'b01) && (t == 8'h78 || t == 8'h33);
      term  = 0;
      foreach (term_types[i]) if (c == 2'b01 && t == term_types[i]) term = 1;
      if (!ipg) begin
        e_net_v = 1; e_net_d = d; e_net_c = c;
      end
      if (ipg) begin
        if (m_frame) e_err = 1;
        else begin
          m_q.push_back(d[63:8]);
          if (m_q.size() == NBLK) finish_msg(was_memv, rdy);
        end
      end else begin
        if (m_q.size() != 0) begin
          e_err = 1;
          m_q.delete();
        end
        if (m_frame) begin
          if (term) m_frame = 0;
        end else if (start) begin
          m_frame = 1;
        end
      end
    end
    if (e_err && e_errcnt != 16'hffff) e_errcnt++;
  endtask

  task automatic check_all();
    check_val("net_valid", net_out_valid, e_net_v);
    if (e_net_v) begin
      check_val("net_d", net_out_d, e_net_d);
      check_val("net_c", net_out_c, e_net_c);
    end
    check_val("mem_valid", mem_valid, e_memv);
    if (e_memv) check_val("mem_out", mem_out, e_mem);
    check_val("ipg_err", ipg_err, e_err);
    check_val("drop_cnt", drop_cnt, e_drop);
    check_val("err_cnt", err_cnt, e_errcnt);
  endtask

  task automatic step(input logic v, input logic [63:0] d, input logic [1:0] c, input logic rdy);
    rx_valid = v; rx_d = d; rx_c = c; mem_ready = rdy;
    model_step(v, d, c, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [63:0] blk(input logic [7:0] t, input logic [55:0] p);
    return {p, t};
  endfunction

  task automatic ipg_blk(input logic [55:0] p, input logic rdy);
    step(1'b1, blk(8'h5a, p), 2'b01, rdy);
  endtask

  task automatic rnd_step(input logic [63:0] d, input logic [1:0] c);
    step($urandom_range(0, 9) != 0, d, c, $urandom_range(0, 3) == 0);
  endtask

  initial begin
    logic [7:0]  kb;
    logic [55:0] pay;
    logic [63:0] rd;
    int          sel;

    reset = 1'b1; rx_valid = 1'b0; rx_d = '0; rx_c = '0; mem_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();

    // T1: term in GAP, then a full message with chunk k = {7{k}}
    step(1'b1, blk(8'h99, 56'h0), 2'b01, 1'b0);
    check_val("t1_term_fwd", net_out_valid, 1'b1);
    for (int k = 0; k < NBLK; k++) begin
      kb = 8'(k);
      ipg_blk({7{kb}}, 1'b0);
      check_val("t1_ipg_not_fwd", net_out_valid, 1'b0);
    end
    check_val("t1_mem_valid", mem_valid, 1'b1);
    check_val("t1_chunk1", mem_out[56 +: 56], {7{8'h01}});
    check_val("t1_chunk8", mem_out[448 +: 56], {7{8'h08}});
    step(1'b0, '0, 2'b00, 1'b1);
    check_val("t1_drain", mem_valid, 1'b0);

    // T2: ordinary frame passes through with latency 1
    step(1'b1, blk(8'h78, 56'h11223344556677), 2'b01, 1'b0);
    step(1'b1, 64'hdeadbeefcafef00d, 2'b10, 1'b0);
    step(1'b1, 64'h0123456789abcdef, 2'b10, 1'b0);
    step(1'b1, blk(8'h87, 56'h0), 2'b01, 1'b0);
    check_val("t2_term_type", net_out_d[7:0], 8'h87);
    check_val("t2_no_mem", mem_valid, 1'b0);

    // T3: partial message aborted by a Start
    for (int k = 0; k < 4; k++) ipg_blk(56'(k + 100), 1'b0);
    step(1'b1, blk(8'h78, 56'h0), 2'b01, 1'b0);
    check_val("t3_err_pulse", ipg_err, 1'b1);
    check_val("t3_err_cnt", err_cnt, 16'd1);
    step(1'b0, '0, 2'b00, 1'b0);
    check_val("t3_err_one_cycle", ipg_err, 1'b0);

    // T5: IPG block inside a frame, then Term back to GAP
    ipg_blk(56'habcdef, 1'b0);
    check_val("t5_err_pulse", ipg_err, 1'b1);
    check_val("t5_not_fwd", net_out_valid, 1'b0);
    step(1'b1, blk(8'hcc, 56'h0), 2'b01, 1'b0);

    // T4: two messages while the holding register stays full
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < NBLK; k++) ipg_blk({$urandom(), 24'($urandom())}, 1'b0);
    check_val("t4_drop", drop_cnt, 16'd1);
    step(1'b0, '0, 2'b00, 1'b1);
    check_val("t4_release", mem_valid, 1'b0);

    // T6: reset during block 6, then a fresh message
    for (int k = 0; k < 5; k++) ipg_blk(56'hfeed00 + 56'(k), 1'b0);
    rx_valid = 1'b1; rx_d = blk(8'h5a, 56'h666666); rx_c = 2'b01;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_val("t6_reset_memv", mem_valid, 1'b0);
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0; rx_valid = 1'b0;
    for (int k = 0; k < NBLK; k++) ipg_blk(56'h0a0a00 + 56'(k), 1'b0);
    check_val("t6_fresh_valid", mem_valid, 1'b1);
    check_val("t6_fresh_chunk0", mem_out[55:0], 56'h0a0a00);

    // Random traffic
    for (int it = 0; it < 1500; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        for (int j = 0; j < int'($urandom_range(NBLK - 2, NBLK + 1)); j++) begin
          pay = {$urandom(), 24'($urandom())};
          rnd_step(blk(8'h5a, pay), 2'b01);
        end
      end else begin
        rd = {$urandom(), $urandom()};
        unique case (sel)
          4: rnd_step(blk(8'h78, rd[63:8]), 2'b01);
          5: rnd_step(blk(term_types[$urandom_range(0, 7)], rd[63:8]), 2'b01);
          6: rnd_step(rd, 2'b10);
          7: rnd_step(blk(8'h1e, rd[63:8]), 2'b01);
          8: rnd_step(rd, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00);
          default: rnd_step(blk(8'h5a, rd[63:8]), 2'b01);
        endcase
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
